// File: rtl/approx_mult_engine_if.sv
// Host-side bus of the approximate multiplier engine: batch control, input RAM
// read port (async) and output RAM write port (sync).
//
// Handshake: the host raises start for one cycle; it is accepted only while the
// engine is idle (busy=0, done=0), otherwise it is dropped. busy rises the cycle
// after an accepted start and falls in the same cycle done pulses for one cycle,
// which is the cycle after the last out_wr. in_data must be valid in the same
// cycle in_addr is presented. Each out_wr cycle is one result write.
interface approx_mult_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_W-1:0]     in_addr;
    logic [DATA_W-1:0]     in_data;
    logic                  out_wr;
    logic [ADDR_W-2:0]     out_addr;
    logic [2*DATA_W-1:0]   out_data;

    // Host controller plus RAM models
    modport master (
        output start, in_data,
        input  busy, done, in_addr, out_wr, out_addr, out_data
    );

    // The engine
    modport slave (
        input  start, in_data,
        output busy, done, in_addr, out_wr, out_addr, out_data
    );
endinterface

// File: rtl/approx_mult_engine.sv
// Leading-one approximate multiplier engine. For each of NUM_PAIRS operand pairs
// it reads a and b from the input RAM, shifts each left to its leading one (capped
// at DATA_W-KEEP_W positions), multiplies the top KEEP_W bits, shifts the product
// back into place and writes it to the output RAM.
// Optional feature macro: APPROX_ROUND_EN -- round the kept bits to nearest
// (saturating) instead of truncating.
module approx_mult_engine #(
    parameter int DATA_W    = 16,
    parameter int KEEP_W    = 8,
    parameter int NUM_PAIRS = 8,
    parameter int ADDR_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    approx_mult_engine_if.slave bus,
    output logic [2:0]         state_dbg
);

    localparam int MAXS = DATA_W - KEEP_W;
    localparam int SW   = $clog2(MAXS + 1);
    localparam int DW   = $clog2(2 * MAXS + 1);
    localparam int KW   = ADDR_W - 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        NORM   = 3'd3,
        MULT   = 3'd4,
        DENORM = 3'd5,
        WRITE  = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_W-1:0]     a_r, b_r;
    logic [SW-1:0]         sa_r, sb_r;
    logic [DW-1:0]         d_r;
    logic [2*DATA_W-1:0]   p_r;
    logic [2*DATA_W-1:0]   out_data_r;
    logic [KW-1:0]         k_r;

    logic                  shift_a, shift_b;
    logic                  last_pair;
    logic [KEEP_W-1:0]     ta, tb;
    logic [2*KEEP_W-1:0]   prod;

    // An operand keeps shifting until its MSB is set or the shift cap is reached;
    // a zero operand therefore stops at the cap with zero kept bits.
    assign shift_a   = !a_r[DATA_W-1] && (sa_r < SW'(MAXS));
    assign shift_b   = !b_r[DATA_W-1] && (sb_r < SW'(MAXS));
    assign last_pair = (k_r == KW'(NUM_PAIRS - 1));

`ifdef APPROX_ROUND_EN
    logic [KEEP_W-1:0] ta_raw, tb_raw;

    // Round the kept bits using the first dropped bit, saturating at all-ones
    always_comb begin
        ta_raw = a_r[DATA_W-1 -: KEEP_W];
        tb_raw = b_r[DATA_W-1 -: KEEP_W];
        ta     = (&ta_raw) ? ta_raw : ta_raw + KEEP_W'(a_r[DATA_W-KEEP_W-1]);
        tb     = (&tb_raw) ? tb_raw : tb_raw + KEEP_W'(b_r[DATA_W-KEEP_W-1]);
    end
`else
    // Plain truncation to the kept bits
    always_comb begin
        ta = a_r[DATA_W-1 -: KEEP_W];
        tb = b_r[DATA_W-1 -: KEEP_W];
    end
`endif

    assign prod = {{KEEP_W{1'b0}}, ta} * {{KEEP_W{1'b0}}, tb};

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded bus outputs
    always_comb begin
        state_nxt    = state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.in_addr  = '0;
        bus.out_wr   = 1'b0;
        bus.out_addr = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LOAD_A;
                end
            end
            LOAD_A: begin
                bus.busy    = 1'b1;
                bus.in_addr = {k_r, 1'b0};
                state_nxt   = LOAD_B;
            end
            LOAD_B: begin
                bus.busy    = 1'b1;
                bus.in_addr = {k_r, 1'b1};
                state_nxt   = NORM;
            end
            NORM: begin
                bus.busy = 1'b1;
                if (!shift_a && !shift_b) begin
                    state_nxt = MULT;
                end
            end
            MULT: begin
                bus.busy  = 1'b1;
                state_nxt = DENORM;
            end
            DENORM: begin
                bus.busy = 1'b1;
                if (d_r == '0) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                bus.busy     = 1'b1;
                bus.out_wr   = 1'b1;
                bus.out_addr = k_r;
                state_nxt    = last_pair ? DONE : LOAD_A;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.out_data = out_data_r;
    assign state_dbg    = state;

    // Datapath: operand capture, normalisation, product build-up and result hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_r        <= '0;
            b_r        <= '0;
            sa_r       <= '0;
            sb_r       <= '0;
            d_r        <= '0;
            p_r        <= '0;
            out_data_r <= '0;
            k_r        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        k_r <= '0;
                    end
                end
                LOAD_A: begin
                    a_r  <= bus.in_data;
                    sa_r <= '0;
                end
                LOAD_B: begin
                    b_r  <= bus.in_data;
                    sb_r <= '0;
                end
                NORM: begin
                    if (shift_a) begin
                        a_r  <= {a_r[DATA_W-2:0], 1'b0};
                        sa_r <= sa_r + 1'b1;
                    end
                    if (shift_b) begin
                        b_r  <= {b_r[DATA_W-2:0], 1'b0};
                        sb_r <= sb_r + 1'b1;
                    end
                end
                MULT: begin
                    p_r <= {{(2*DATA_W-2*KEEP_W){1'b0}}, prod};
                    d_r <= DW'(2 * MAXS) - DW'(sa_r) - DW'(sb_r);
                end
                DENORM: begin
                    if (d_r != '0) begin
                        p_r <= {p_r[2*DATA_W-2:0], 1'b0};
                        d_r <= d_r - 1'b1;
                    end else begin
                        // p is final here; hold it on out_data through WRITE and beyond
                        out_data_r <= p_r;
                    end
                end
                WRITE: begin
                    if (!last_pair) begin
                        k_r <= k_r + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_engine.sv
// Directed bench for approx_mult_engine: reset values, an 8-pair batch of
// hand-computed products, start while busy, back-to-back batches and reset abort.
module tb_approx_mult_engine;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NP     = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_DENORM = 3'd5;

    logic        clk;
    logic        rst;
    logic [2:0]  state_dbg;

    approx_mult_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    approx_mult_engine #(
        .DATA_W(DATA_W), .KEEP_W(8), .NUM_PAIRS(NP), .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input RAM model with asynchronous read
    logic [DATA_W-1:0] in_ram [16];
    assign bus.in_data = in_ram[bus.in_addr];

    // Output-side monitor, sampled on the falling edge
    int                  cyc = 0;
    int                  done_cnt = 0;
    int                  done_cyc = 0;
    logic [ADDR_W-2:0]   wr_addr_q[$];
    logic [2*DATA_W-1:0] wr_data_q[$];
    int                  wr_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_wr) begin
            wr_addr_q.push_back(bus.out_addr);
            wr_data_q.push_back(bus.out_data);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Hand-computed pairs and approximate products
    logic [DATA_W-1:0]   pa  [NP];
    logic [DATA_W-1:0]   pb  [NP];
    logic [2*DATA_W-1:0] exp_p [NP];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ram();
        pa[0] = 16'h8000; pb[0] = 16'h8000; exp_p[0] = 32'h4000_0000;
        pa[1] = 16'h0003; pb[1] = 16'h0005; exp_p[1] = 32'h0000_000F;
        pa[2] = 16'h1234; pb[2] = 16'h0100;
`ifdef APPROX_ROUND_EN
        exp_p[2] = 32'h0012_4000;
`else
        exp_p[2] = 32'h0012_2000;
`endif
        pa[3] = 16'h0000; pb[3] = 16'hFFFF; exp_p[3] = 32'h0000_0000;
        pa[4] = 16'hFFFF; pb[4] = 16'hFFFF; exp_p[4] = 32'hFE01_0000;
        pa[5] = 16'h00FF; pb[5] = 16'h0002; exp_p[5] = 32'h0000_01FE;
        pa[6] = 16'h0100; pb[6] = 16'h0100; exp_p[6] = 32'h0001_0000;
        pa[7] = 16'h4000; pb[7] = 16'h0001; exp_p[7] = 32'h0000_4000;
        for (int i = 0; i < NP; i++) begin
            in_ram[2*i]   = pa[i];
            in_ram[2*i+1] = pb[i];
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for the done pulse; returns at the falling edge of the done cycle
    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (3) tick();
        chk_cnt++;
        if ({state_dbg, bus.busy, bus.done, bus.out_wr} !== 6'b0)
            $display("FAIL reset_ctrl: state/busy/done/wr=%b required 000000",
                     {state_dbg, bus.busy, bus.done, bus.out_wr});
        else pass_cnt++;
        chk_cnt++;
        if (bus.in_addr !== '0 || bus.out_addr !== '0 || bus.out_data !== '0)
            $display("FAIL reset_bus: in_addr=%h out_addr=%h out_data=%h required 0",
                     bus.in_addr, bus.out_addr, bus.out_data);
        else pass_cnt++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_batch();
        int base;
        int d0;
        int s;
        bit ok;
        base = wr_data_q.size();
        d0   = done_cnt;
        pulse_start();
        s = cyc;
        chk_cnt++;
        if (state_dbg !== S_LOAD_A || bus.busy !== 1'b1 || bus.in_addr !== 4'd0)
            $display("FAIL batch_accept: state=%0d busy=%b in_addr=%h required 1 1 0",
                     state_dbg, bus.busy, bus.in_addr);
        else pass_cnt++;
        wait_done(3000, ok);
        chk_cnt++;
        if (!ok) $display("FAIL batch_timeout: done=0 required 1 within 3000 cycles");
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (wr_data_q.size() - base !== NP)
            $display("FAIL batch_wr_count: got %0d required %0d", wr_data_q.size() - base, NP);
        else pass_cnt++;
        if (wr_data_q.size() - base == NP) begin
            // Pair 0 has no normalising shifts and a 16-step denormalise
            chk_cnt++;
            if (wr_cyc_q[base] - s !== 21)
                $display("FAIL pair0_latency: got %0d required 21", wr_cyc_q[base] - s);
            else pass_cnt++;
            for (int i = 0; i < NP; i++) begin
                chk_cnt++;
                if (wr_addr_q[base+i] !== 3'(i) || wr_data_q[base+i] !== exp_p[i])
                    $display("FAIL pair%0d: addr=%0d data=%h required addr=%0d data=%h",
                             i, wr_addr_q[base+i], wr_data_q[base+i], i, exp_p[i]);
                else pass_cnt++;
            end
            chk_cnt++;
            if (done_cnt - d0 !== 1 || done_cyc !== wr_cyc_q[base+NP-1] + 1)
                $display("FAIL batch_done: pulses=%0d cyc=%0d required 1 at %0d",
                         done_cnt - d0, done_cyc, wr_cyc_q[base+NP-1] + 1);
            else pass_cnt++;
        end
        chk_cnt++;
        if (bus.busy !== 1'b0 || state_dbg !== S_IDLE || bus.out_data !== exp_p[NP-1])
            $display("FAIL batch_idle_hold: busy=%b state=%0d out_data=%h required 0 0 %h",
                     bus.busy, state_dbg, bus.out_data, exp_p[NP-1]);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        int base;
        int d0;
        bit ok;
        base = wr_data_q.size();
        d0   = done_cnt;
        pulse_start();
        repeat (5) tick();
        pulse_start();
        wait_done(3000, ok);
        chk_cnt++;
        if (!ok) $display("FAIL busy_start_timeout: done=0 required 1");
        else pass_cnt++;
        repeat (60) tick();
        chk_cnt++;
        if (wr_data_q.size() - base !== NP || done_cnt - d0 !== 1 || state_dbg !== S_IDLE)
            $display("FAIL busy_start: writes=%0d dones=%0d state=%0d required %0d 1 0",
                     wr_data_q.size() - base, done_cnt - d0, state_dbg, NP);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        pulse_start();
        wait_done(3000, ok);
        chk_cnt++;
        if (!ok) $display("FAIL b2b_first_timeout: done=0 required 1");
        else pass_cnt++;
        base = wr_data_q.size();
        @(posedge clk);
        #1;
        pulse_start();
        chk_cnt++;
        if (state_dbg !== S_LOAD_A || bus.busy !== 1'b1)
            $display("FAIL b2b_accept: state=%0d busy=%b required 1 1", state_dbg, bus.busy);
        else pass_cnt++;
        wait_done(3000, ok);
        tick();
        chk_cnt++;
        if (!ok || wr_data_q.size() - base !== NP || wr_data_q[wr_data_q.size()-1] !== exp_p[NP-1])
            $display("FAIL b2b_second: done=%b writes=%0d required 1 %0d", ok,
                     wr_data_q.size() - base, NP);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_batch();
        int base;
        int d0;
        bit hit;
        base = wr_data_q.size();
        d0   = done_cnt;
        hit  = 1'b0;
        pulse_start();
        for (int i = 0; i < 3000; i++) begin
            if (wr_data_q.size() - base == 3 && state_dbg == S_DENORM) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk_cnt++;
        if (!hit) $display("FAIL abort_reach: pair 3 DENORM not seen within 3000 cycles");
        else pass_cnt++;
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (state_dbg !== S_IDLE || bus.busy !== 1'b0 || bus.out_wr !== 1'b0 || bus.out_data !== '0)
            $display("FAIL abort_state: state=%0d busy=%b wr=%b out_data=%h required 0 0 0 0",
                     state_dbg, bus.busy, bus.out_wr, bus.out_data);
        else pass_cnt++;
        rst = 1'b1;
        repeat (200) tick();
        chk_cnt++;
        if (wr_data_q.size() - base !== 3 || done_cnt !== d0)
            $display("FAIL abort_quiet: writes=%0d dones=%0d required 3 0",
                     wr_data_q.size() - base, done_cnt - d0);
        else pass_cnt++;
    endtask

    initial begin
        bus.start = 1'b0;
        rst = 1'b0;
        load_ram();
        test_reset();
        test_batch();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_batch();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
